regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file: next generation of the CPU datapath's 32×32 register file. Width and depth are generic. It provides two registered read ports, one write port, optional write-to-read bypass, an optional hardwired-zero entry 0, and a synchronous clear sequencer that zeroes the array one entry per cycle. It sits between decode (read addresses) and writeback (write port) in the datapath.

## Interface
- DATA_W, 32, entry width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1: entry 0 always reads 0 and writes to it are dropped
- BYPASS, 1, 1: same-edge write to a read address is forwarded to the read output

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears array, outputs, FSM
- enable  in  1  global enable; 0 freezes all state, including the sweep
- rd_en  in  1  read request for both ports
- rd1_addr, rd2_addr  in  ADDR_W  read addresses
- rd1_data, rd2_data  out  DATA_W  registered read data; held between reads
- rd_valid  out  1  high for one cycle after an accepted read
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clr_req  in  1  request a full-array clear sweep
- busy  out  1  high while the sweep is in progress

## Operation
- FSM states: IDLE, SWEEP. Sweep index idx is ADDR_W bits.
- Reset (reset=0, asynchronous):
  - All entries = 0; rd1_data = rd2_data = 0; rd_valid = 0; busy = 0; state = IDLE; idx = 0.
  - Takes effect immediately, including mid-sweep.
- With enable=0, nothing changes: array, outputs, state and idx all hold.
  - rd_valid holds its last value; benches drive enable=1 when checking pulses.
- IDLE with enable=1 and clr_req=1:
  - Go to SWEEP with idx = 0.
  - rd_en and wr_en in that cycle are ignored; rd_valid goes to 0.
- IDLE with enable=1 and clr_req=0:
  - If wr_en=1: entry[wr_addr] ← wr_data, except entry 0 when ZERO_REG=1.
  - If rd_en=1: rdN_data ← entry[rdN_addr] as it was before the edge, and rd_valid ← 1. Otherwise rd_valid ← 0 and the data outputs hold.
  - BYPASS=1 with wr_en=1, rd_en=1 and rdN_addr == wr_addr: rdN_data ← wr_data. This is suppressed when the address is 0 and ZERO_REG=1.
  - ZERO_REG=1 and rdN_addr == 0: rdN_data ← 0.
  - Both ports may read the same address; each port resolves independently.
- SWEEP with enable=1:
  - entry[idx] ← 0, then idx ← idx+1.
  - On idx == DEPTH-1: go to IDLE and set idx ← 0. The wrap is explicit, with no overflow into a wider counter.
  - rd_en, wr_en and clr_req are ignored; rd_valid ← 0.
- busy = (state == SWEEP), registered.

## Timing
- Read latency is 1 cycle: rd_en at edge k gives data and rd_valid=1 after edge k, valid for the cycle k..k+1.
- Write latency is 1 cycle: a write at edge k is visible to a read sampled at edge k+1. It is visible at edge k itself only with BYPASS=1.
- Back-to-back reads and writes are accepted every cycle; there is no stall outside SWEEP.
- Clear timing:
  - clr_req accepted at edge k: busy=1 after edge k.
  - Entries 0..DEPTH-1 are cleared at edges k+1..k+DEPTH.
  - busy=0 after edge k+DEPTH; the first accepted operation is at edge k+DEPTH+1.
  - Total: DEPTH+1 cycles with enable held high. Each enable=0 cycle extends this by one.
- clr_req is level-sampled only in IDLE. Holding it high re-triggers a sweep immediately after the current one ends.
- Reset release: the first edge with reset=1 is a normal IDLE cycle.

## Test plan
- Reset check: assert reset=0 after writing 32'hDEAD_BEEF to entry 7, then release and read entries 7 and 0. Required: rd1_data = rd2_data = 0, rd_valid = 1 one cycle after the read.
- Basic write/read: write 111111 to entry 30 and 9999999 to entry 10, then read rd1_addr=30, rd2_addr=10 one cycle later. Required: 111111 and 9999999, rd_valid pulses for one cycle.
- Bypass: same edge wr_addr=5, wr_data=32'hA5A5_A5A5, rd1_addr=5, rd2_addr=5, entry 5 previously 3.
  - BYPASS=1: both outputs = A5A5A5A5.
  - BYPASS=0: both outputs = 3, then A5A5A5A5 on the next read.
- Zero register: ZERO_REG=1, write 32'hFFFF_FFFF to entry 0, then read entry 0 on both ports with a same-edge bypass attempt. Required: 0 on both ports. With ZERO_REG=0: FFFFFFFF.
- Sweep: fill all 32 entries with index+1, then pulse clr_req one cycle.
  - Required: busy=1 for exactly 32 cycles, and writes/reads issued during that time are dropped (rd_valid=0).
  - Afterwards every entry reads 0. An enable=0 gap of 3 cycles stretches busy to 35 cycles.
- Reset mid-sweep: assert reset=0 at sweep index 12. Required: busy=0 immediately, state IDLE, all entries 0, and the next write/read works on the first edge after release.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: two registered read ports, one write port, optional
// write-to-read bypass, optional hardwired-zero entry 0 and a one-entry-per-cycle clear sweep.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd1_addr,
   input  logic [ADDR_W-1:0] rd2_addr,
   output logic [DATA_W-1:0] rd1_data,
   output logic [DATA_W-1:0] rd2_data,
   output logic              rd_valid,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr_req,
   output logic              busy,
   output logic              state_dbg
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   idx;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   rd1_next;
   logic [DATA_W-1:0]   rd2_next;
   logic                wr_allowed;

   // Handshake: there is no back-pressure. In IDLE with enable=1 and clr_req=0 every
   // rd_en/wr_en is accepted on that edge; an accepted read raises rd_valid for the
   // following cycle with the data on rd1_data/rd2_data, which hold until the next read.
   assign state_dbg = (state == SWEEP);

   // Each port resolves independently: array, then same-edge bypass, then zero entry.
   always_comb begin
      rd1_next = mem[rd1_addr];
      if (BYPASS && wr_en && (wr_addr == rd1_addr)) begin
         rd1_next = wr_data;
      end
      if (ZERO_REG && (rd1_addr == '0)) begin
         rd1_next = '0;
      end
   end

   always_comb begin
      rd2_next = mem[rd2_addr];
      if (BYPASS && wr_en && (wr_addr == rd2_addr)) begin
         rd2_next = wr_data;
      end
      if (ZERO_REG && (rd2_addr == '0)) begin
         rd2_next = '0;
      end
   end

   assign wr_allowed = wr_en && !(ZERO_REG && (wr_addr == '0));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         idx      <= '0;
         busy     <= 1'b0;
         rd_valid <= 1'b0;
         rd1_data <= '0;
         rd2_data <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (enable) begin
         case (state)
            IDLE: begin
               if (clr_req) begin
                  state    <= SWEEP;
                  busy     <= 1'b1;
                  idx      <= '0;
                  rd_valid <= 1'b0;
               end else begin
                  if (wr_allowed) begin
                     mem[wr_addr] <= wr_data;
                  end
                  rd_valid <= rd_en;
                  if (rd_en) begin
                     rd1_data <= rd1_next;
                     rd2_data <= rd2_next;
                  end
               end
            end
            SWEEP: begin
               mem[idx] <= '0;
               rd_valid <= 1'b0;
               // Explicit wrap back to 0 on the last entry.
               if (idx == LAST_IDX) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  idx   <= '0;
               end else begin
                  idx <= idx + ADDR_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               idx      <= '0;
               rd_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (zero-reg+bypass, and neither) fed the same
// stimulus, checked against a reference model and explicit constants.
module tb_regfile_mp;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          rd_en;
   logic [AW-1:0] rd1_addr;
   logic [AW-1:0] rd2_addr;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          clr_req;

   logic [DW-1:0] z_rd1, z_rd2, n_rd1, n_rd2;
   logic          z_valid, n_valid, z_busy, n_busy, z_state, n_state;

   // Reference model state
   logic [DW-1:0] mem_z [DEPTH];
   logic [DW-1:0] mem_n [DEPTH];
   logic          m_sweep;
   logic [AW-1:0] m_idx;
   logic          m_valid;
   logic [DW-1:0] m_z1, m_z2, m_n1, m_n2;
   logic [DW-1:0] exp_q[$];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_z (
      .clk(clk), .reset(reset), .enable(enable), .rd_en(rd_en),
      .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .rd1_data(z_rd1), .rd2_data(z_rd2),
      .rd_valid(z_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .clr_req(clr_req), .busy(z_busy), .state_dbg(z_state)
   );

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_n (
      .clk(clk), .reset(reset), .enable(enable), .rd_en(rd_en),
      .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .rd1_data(n_rd1), .rd2_data(n_rd2),
      .rd_valid(n_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .clr_req(clr_req), .busy(n_busy), .state_dbg(n_state)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         mem_z[i] = '0;
         mem_n[i] = '0;
      end
      m_sweep = 1'b0; m_idx = '0; m_valid = 1'b0;
      m_z1 = '0; m_z2 = '0; m_n1 = '0; m_n2 = '0;
      exp_q.delete();
   endtask

   task automatic idle_inputs();
      enable = 1'b1; rd_en = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
   endtask

   // Advance the model for the coming edge, take the edge, then check all outputs.
   task automatic tick();
      logic          acc;
      logic [DW-1:0] e;
      logic [5:0]    ctrl_exp;
      acc = 1'b0;
      if (enable) begin
         if (m_sweep) begin
            mem_z[m_idx] = '0;
            mem_n[m_idx] = '0;
            m_valid = 1'b0;
            if (m_idx == AW'(DEPTH - 1)) begin
               m_sweep = 1'b0;
               m_idx = '0;
            end else begin
               m_idx = m_idx + AW'(1);
            end
         end else if (clr_req) begin
            m_sweep = 1'b1; m_idx = '0; m_valid = 1'b0;
         end else begin
            if (rd_en) begin
               acc = 1'b1;
               e = mem_z[rd1_addr];
               if (wr_en && wr_addr == rd1_addr) e = wr_data;
               if (rd1_addr == '0) e = '0;
               exp_q.push_back(e);
               e = mem_z[rd2_addr];
               if (wr_en && wr_addr == rd2_addr) e = wr_data;
               if (rd2_addr == '0) e = '0;
               exp_q.push_back(e);
               exp_q.push_back(mem_n[rd1_addr]);
               exp_q.push_back(mem_n[rd2_addr]);
            end
            m_valid = rd_en;
            if (wr_en) begin
               if (wr_addr != '0) mem_z[wr_addr] = wr_data;
               mem_n[wr_addr] = wr_data;
            end
         end
      end
      @(posedge clk);
      #1;
      if (acc) begin
         m_z1 = exp_q.pop_front();
         m_z2 = exp_q.pop_front();
         m_n1 = exp_q.pop_front();
         m_n2 = exp_q.pop_front();
      end
      ctrl_exp = {m_sweep, m_sweep, m_valid, m_valid, m_sweep, m_sweep};
      n_vec++;
      if ({z_busy, n_busy, z_valid, n_valid, z_state, n_state} !== ctrl_exp) begin
         n_err++;
         $display("FAIL ctrl t=%0t busy/valid/state got %b expected %b", $time,
                  {z_busy, n_busy, z_valid, n_valid, z_state, n_state}, ctrl_exp);
      end
      n_vec++;
      if ({z_rd1, z_rd2} !== {m_z1, m_z2}) begin
         n_err++;
         $display("FAIL data_z t=%0t got %h/%h expected %h/%h", $time, z_rd1, z_rd2, m_z1, m_z2);
      end
      n_vec++;
      if ({n_rd1, n_rd2} !== {m_n1, m_n2}) begin
         n_err++;
         $display("FAIL data_n t=%0t got %h/%h expected %h/%h", $time, n_rd1, n_rd2, m_n1, m_n2);
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      idle_inputs();
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      idle_inputs();
      rd_en = 1'b1; rd1_addr = a1; rd2_addr = a2;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic fill_all();
      for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'(i + 1));
   endtask

   task automatic test_reset();
      wr(7, 32'hDEAD_BEEF);
      rd(7, 7);
      reset = 1'b0;
      #1;
      model_reset();
      n_vec++;
      if ({z_rd1, z_rd2, n_rd1, n_rd2} !== '0) begin
         n_err++;
         $display("FAIL reset_data got %h %h %h %h expected 0", z_rd1, z_rd2, n_rd1, n_rd2);
      end
      n_vec++;
      if ({z_busy, n_busy, z_valid, n_valid, z_state, n_state} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_ctrl got %b expected 000000",
                  {z_busy, n_busy, z_valid, n_valid, z_state, n_state});
      end
      #2;
      reset = 1'b1;
      rd(7, 0);
      n_vec++;
      if ({z_rd1, z_rd2, n_rd1, n_rd2, z_valid} !== {128'h0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_read got %h %h %h %h v=%b expected 0 0 0 0 v=1",
                  z_rd1, z_rd2, n_rd1, n_rd2, z_valid);
      end
   endtask

   task automatic test_basic();
      wr(30, 32'd111111);
      wr(10, 32'd9999999);
      rd(30, 10);
      n_vec++;
      if ({z_rd1, z_rd2, n_rd1, n_rd2, z_valid} !== {32'd111111, 32'd9999999, 32'd111111, 32'd9999999, 1'b1}) begin
         n_err++;
         $display("FAIL basic_read got %0d %0d %0d %0d v=%b expected 111111 9999999 111111 9999999 v=1",
                  z_rd1, z_rd2, n_rd1, n_rd2, z_valid);
      end
      idle_inputs();
      tick();
      n_vec++;
      if (z_valid !== 1'b0 || n_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_pulse rd_valid got %b/%b expected 0/0", z_valid, n_valid);
      end
   endtask

   task automatic test_bypass();
      wr(5, 32'd3);
      idle_inputs();
      wr_en = 1'b1; wr_addr = 5; wr_data = 32'hA5A5_A5A5;
      rd_en = 1'b1; rd1_addr = 5; rd2_addr = 5;
      tick();
      n_vec++;
      if ({z_rd1, z_rd2} !== {2{32'hA5A5_A5A5}}) begin
         n_err++;
         $display("FAIL bypass_on got %h %h expected a5a5a5a5 a5a5a5a5", z_rd1, z_rd2);
      end
      n_vec++;
      if ({n_rd1, n_rd2} !== {32'd3, 32'd3}) begin
         n_err++;
         $display("FAIL bypass_off got %h %h expected 3 3", n_rd1, n_rd2);
      end
      rd(5, 5);
      n_vec++;
      if ({n_rd1, n_rd2} !== {2{32'hA5A5_A5A5}}) begin
         n_err++;
         $display("FAIL bypass_off_next got %h %h expected a5a5a5a5 a5a5a5a5", n_rd1, n_rd2);
      end
   endtask

   task automatic test_zero_reg();
      wr(0, 32'hFFFF_FFFF);
      idle_inputs();
      wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
      rd_en = 1'b1; rd1_addr = 0; rd2_addr = 0;
      tick();
      n_vec++;
      if ({z_rd1, z_rd2} !== 64'h0) begin
         n_err++;
         $display("FAIL zero_reg_on got %h %h expected 0 0", z_rd1, z_rd2);
      end
      n_vec++;
      if ({n_rd1, n_rd2} !== {2{32'hFFFF_FFFF}}) begin
         n_err++;
         $display("FAIL zero_reg_off got %h %h expected ffffffff ffffffff", n_rd1, n_rd2);
      end
   endtask

   // Run one sweep with random dropped traffic; optional 3-cycle enable gap.
   task automatic run_sweep(input bit gap, input int exp_cycles, input string tag);
      int cnt;
      int bad_valid;
      fill_all();
      idle_inputs();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      cnt = 0;
      bad_valid = 0;
      while (z_busy === 1'b1 && cnt < 200) begin
         cnt++;
         enable   = !(gap && cnt >= 10 && cnt < 13);
         rd_en    = 1'b1;
         wr_en    = $urandom_range(0, 1);
         rd1_addr = AW'($urandom_range(0, DEPTH - 1));
         rd2_addr = AW'($urandom_range(0, DEPTH - 1));
         wr_addr  = AW'($urandom_range(0, DEPTH - 1));
         wr_data  = $urandom;
         clr_req  = $urandom_range(0, 1);
         tick();
         if (z_valid !== 1'b0 || n_valid !== 1'b0) bad_valid++;
      end
      idle_inputs();
      n_vec++;
      if (cnt != exp_cycles) begin
         n_err++;
         $display("FAIL %s busy_cycles got %0d expected %0d", tag, cnt, exp_cycles);
      end
      n_vec++;
      if (bad_valid != 0) begin
         n_err++;
         $display("FAIL %s dropped_reads rd_valid high %0d times expected 0", tag, bad_valid);
      end
      for (int i = 0; i < DEPTH; i++) begin
         rd(AW'(i), AW'(DEPTH - 1 - i));
         n_vec++;
         if ({z_rd1, z_rd2, n_rd1, n_rd2} !== 128'h0) begin
            n_err++;
            $display("FAIL %s cleared entry %0d got %h %h %h %h expected 0", tag, i,
                     z_rd1, z_rd2, n_rd1, n_rd2);
         end
      end
   endtask

   task automatic test_sweep();
      run_sweep(1'b0, DEPTH, "sweep");
      run_sweep(1'b1, DEPTH + 3, "sweep_gap");
   endtask

   task automatic test_reset_mid_sweep();
      fill_all();
      idle_inputs();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      repeat (12) tick();
      reset = 1'b0;
      #1;
      model_reset();
      n_vec++;
      if ({z_busy, n_busy, z_state, n_state} !== 4'b0) begin
         n_err++;
         $display("FAIL mid_sweep_reset busy/state got %b expected 0000",
                  {z_busy, n_busy, z_state, n_state});
      end
      #2;
      reset = 1'b1;
      idle_inputs();
      wr_en = 1'b1; wr_addr = 20; wr_data = 32'h0000_1234;
      rd_en = 1'b1; rd1_addr = 20; rd2_addr = 13;
      tick();
      n_vec++;
      if ({z_rd1, z_rd2, n_rd1, n_rd2, z_valid} !== {32'h1234, 32'h0, 32'h0, 32'h0, 1'b1}) begin
         n_err++;
         $display("FAIL after_reset_op got %h %h %h %h v=%b expected 1234 0 0 0 v=1",
                  z_rd1, z_rd2, n_rd1, n_rd2, z_valid);
      end
      rd(20, 31);
      n_vec++;
      if ({z_rd1, z_rd2, n_rd1, n_rd2} !== {32'h1234, 32'h0, 32'h1234, 32'h0}) begin
         n_err++;
         $display("FAIL after_reset_read got %h %h %h %h expected 1234 0 1234 0",
                  z_rd1, z_rd2, n_rd1, n_rd2);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 80; i++) begin
         enable   = ($urandom_range(0, 7) != 0);
         clr_req  = 1'b0;
         rd_en    = $urandom_range(0, 1);
         wr_en    = $urandom_range(0, 1);
         rd1_addr = AW'($urandom_range(0, 7));
         rd2_addr = AW'($urandom_range(0, 7));
         wr_addr  = AW'($urandom_range(0, 7));
         wr_data  = $urandom;
         tick();
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      rd1_addr = '0; rd2_addr = '0; wr_addr = '0; wr_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({z_rd1, z_rd2, n_rd1, n_rd2, z_valid, n_valid, z_busy, n_busy} !== '0) begin
         n_err++;
         $display("FAIL power_on_reset got %h %h %h %h %b%b%b%b expected all 0",
                  z_rd1, z_rd2, n_rd1, n_rd2, z_valid, n_valid, z_busy, n_busy);
      end
      #2;
      reset = 1'b1;
      test_reset();
      test_basic();
      test_bypass();
      test_zero_reg();
      test_back_to_back();
      test_sweep();
      test_reset_mid_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
